mem_test_memory_responder: RTL and testbench

//  Memory-side responder for the memory test device: serves its word write/read requests over a

---
 rtl/mem_test_pkg.sv | 15 +
 rtl/mem_test_ram.sv | 26 ++
 rtl/mem_test_memory_responder.sv | 124 ++++++++++++
 tb/tb_mem_test_memory_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_test_pkg.sv
// Shared types for the memory test device responder: FSM state encoding and
// latency counter width.
package mem_test_pkg;

  localparam int LAT_CNT_W = 4;

  typedef enum logic [2:0] {
    s_idle,
    s_write_wait,
    s_write_ack,
    s_read_wait,
    s_read_valid
  } mem_resp_state_t;

endpackage

// File: rtl/mem_test_ram.sv
// Word RAM behind the responder: synchronous write port, asynchronous read port.
module mem_test_ram #(
  parameter int DATUM_WIDTH = 8,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   i_clk,
  input  logic                   we,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [DATUM_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]  raddr,
  output logic [DATUM_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATUM_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; contents must survive a responder reset, and a
  // reset loop over every word would also stop this mapping onto RAM primitives.
  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_test_memory_responder.sv
// Memory-side responder: serves word write/read requests with programmable
// latency from an internal RAM, with optional per-address read bit-fault injection.
module mem_test_memory_responder
  import mem_test_pkg::*;
#(
  parameter int DATUM_WIDTH   = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int WRITE_LATENCY = 1,
  parameter int READ_LATENCY  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_write_req,
  input  logic                   i_read_req,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [DATUM_WIDTH-1:0] i_wdata,
  input  logic                   i_fault_ena,
  input  logic [ADDR_WIDTH-1:0]  i_fault_addr,
  input  logic [DATUM_WIDTH-1:0] i_fault_mask,
  output logic                   o_memory_write_ready,
  output logic                   o_memory_read_valid,
  output logic [DATUM_WIDTH-1:0] o_rdata,
  output logic                   o_busy
);

  mem_resp_state_t        state, state_next;
  logic [LAT_CNT_W-1:0]   lat_cnt, lat_cnt_next;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATUM_WIDTH-1:0] wdata_q;
  logic [DATUM_WIDTH-1:0] ram_rdata, rdata_next;
  logic                   capture, commit, ram_we, rdata_load;
  logic                   ready_next, valid_next, fault_hit;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next   = state;
    lat_cnt_next = lat_cnt;
    capture      = 1'b0;
    commit       = 1'b0;
    rdata_load   = 1'b0;
    ready_next   = 1'b0;
    valid_next   = 1'b0;
    case (state)
      s_idle: begin
        if (i_write_req) begin
          capture      = 1'b1;
          lat_cnt_next = LAT_CNT_W'(WRITE_LATENCY - 1);
          state_next   = s_write_wait;
        end else if (i_read_req) begin
          capture      = 1'b1;
          lat_cnt_next = LAT_CNT_W'(READ_LATENCY - 1);
          state_next   = s_read_wait;
        end
      end
      s_write_wait: begin
        if (lat_cnt == '0) begin
          commit     = 1'b1;
          ready_next = 1'b1;
          state_next = s_write_ack;
        end else begin
          lat_cnt_next = lat_cnt - LAT_CNT_W'(1);
        end
      end
      s_write_ack: state_next = s_idle;
      s_read_wait: begin
        if (lat_cnt == '0) begin
          rdata_load = 1'b1;
          valid_next = 1'b1;
          state_next = s_read_valid;
        end else begin
          lat_cnt_next = lat_cnt - LAT_CNT_W'(1);
        end
      end
      s_read_valid: state_next = s_idle;
      default:      state_next = s_idle;
    endcase
  end

  // The write lands on the edge entering s_write_ack, so a reset on that edge drops it.
  assign ram_we     = commit && !i_rst;
  assign fault_hit  = i_fault_ena && (addr_q == i_fault_addr);
  assign rdata_next = ram_rdata ^ (fault_hit ? i_fault_mask : '0);
  assign o_busy     = (state != s_idle);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                <= s_idle;
      lat_cnt              <= '0;
      o_memory_write_ready <= 1'b0;
      o_memory_read_valid  <= 1'b0;
      o_rdata              <= '0;
    end else begin
      state                <= state_next;
      lat_cnt              <= lat_cnt_next;
      o_memory_write_ready <= ready_next;
      o_memory_read_valid  <= valid_next;
      if (rdata_load) o_rdata <= rdata_next;
    end
  end

  // Request capture registers are only meaningful after acceptance; no reset needed.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      addr_q  <= i_addr;
      wdata_q <= i_wdata;
    end
  end

  mem_test_ram #(
    .DATUM_WIDTH(DATUM_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk(i_clk),
    .we   (ram_we),
    .waddr(addr_q),
    .wdata(wdata_q),
    .raddr(addr_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mem_test_memory_responder.sv
// Self-checking bench for mem_test_memory_responder: directed transaction table,
// multi-cycle corner sequences, then randomized traffic against a transaction-level model.
module tb_mem_test_memory_responder;

  localparam int DW       = 8;
  localparam int AW       = 8;
  localparam int WL       = 1;
  localparam int RL       = 2;
  localparam int MAX_WAIT = 40;
  localparam int N_RAND   = 3000;
  localparam int NV       = 8;

  logic          clk = 1'b0;
  logic          rst, write_req, read_req, fault_ena;
  logic [AW-1:0] addr, fault_addr;
  logic [DW-1:0] wdata, fault_mask;
  logic          ready, valid, busy;
  logic [DW-1:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_test_memory_responder #(
    .DATUM_WIDTH  (DW),
    .ADDR_WIDTH   (AW),
    .WRITE_LATENCY(WL),
    .READ_LATENCY (RL)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_write_req         (write_req),
    .i_read_req          (read_req),
    .i_addr              (addr),
    .i_wdata             (wdata),
    .i_fault_ena         (fault_ena),
    .i_fault_addr        (fault_addr),
    .i_fault_mask        (fault_mask),
    .o_memory_write_ready(ready),
    .o_memory_read_valid (valid),
    .o_rdata             (rdata),
    .o_busy              (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string         name;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          fe;
    logic [AW-1:0] fa;
    logic [DW-1:0] fm;
    logic [DW-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic fe, input logic [AW-1:0] fa,
                              input logic [DW-1:0] fm, input logic [DW-1:0] exp);
    vec_t v;
    v.name = name; v.wr = wr; v.a = a; v.d = d;
    v.fe = fe; v.fa = fa; v.fm = fm; v.exp = exp;
    return v;
  endfunction

  // Called on a negedge in an idle cycle. Returns the number of cycles from the
  // accepting cycle to the completion pulse, or -1 if none arrived in time.
  task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat);
    write_req = wr;
    read_req  = !wr;
    addr      = a;
    wdata     = d;
    lat       = -1;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      @(negedge clk);
      write_req = 1'b0;
      read_req  = 1'b0;
      if (wr ? ready : valid) begin
        lat = k;
        break;
      end
    end
  endtask

  vec_t          vecs [NV];
  logic [DW-1:0] mem_m [2**AW];

  initial begin
    int   lat, pulses, n, e, idle_from, acc, lat_m;
    logic seen_valid, pend, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_rdata, held;

    vecs[0] = mk("wr05",         1'b1, 8'h05, 8'hA5, 1'b0, 8'h00, 8'h00, 8'h00);
    vecs[1] = mk("wr06",         1'b1, 8'h06, 8'h5A, 1'b0, 8'h00, 8'h00, 8'h00);
    vecs[2] = mk("wr20",         1'b1, 8'h20, 8'h11, 1'b0, 8'h00, 8'h00, 8'h00);
    vecs[3] = mk("rd05",         1'b0, 8'h05, 8'h00, 1'b0, 8'h00, 8'h00, 8'hA5);
    vecs[4] = mk("rd05_fault",   1'b0, 8'h05, 8'h00, 1'b1, 8'h05, 8'h01, 8'hA4);
    vecs[5] = mk("rd06_nofault", 1'b0, 8'h06, 8'h00, 1'b1, 8'h05, 8'h01, 8'h5A);
    vecs[6] = mk("rd06_fault",   1'b0, 8'h06, 8'h00, 1'b1, 8'h06, 8'hFF, 8'hA5);
    vecs[7] = mk("rd20",         1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 8'h00, 8'h11);

    rst = 1'b1; write_req = 1'b0; read_req = 1'b0; addr = '0; wdata = '0;
    fault_ena = 1'b0; fault_addr = '0; fault_mask = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 32'(0));
    check("reset_valid", 32'(valid), 32'(0));
    check("reset_rdata", 32'(rdata), 32'(0));
    check("reset_busy",  32'(busy),  32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Directed transaction table
    for (int i = 0; i < NV; i++) begin
      fault_ena  = vecs[i].fe;
      fault_addr = vecs[i].fa;
      fault_mask = vecs[i].fm;
      run_txn(vecs[i].wr, vecs[i].a, vecs[i].d, lat);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].wr ? WL + 1 : RL + 1));
      if (!vecs[i].wr) check({vecs[i].name, "_rdata"}, 32'(rdata), 32'(vecs[i].exp));
      @(negedge clk);
      check({vecs[i].name, "_pulse_width"}, 32'(vecs[i].wr ? ready : valid), 32'(0));
      check({vecs[i].name, "_idle_gap"}, 32'(busy), 32'(0));
      if (!vecs[i].wr) check({vecs[i].name, "_rdata_held"}, 32'(rdata), 32'(vecs[i].exp));
    end
    fault_ena = 1'b0;

    // Both requests in idle: only the write is serviced
    write_req = 1'b1; read_req = 1'b1; addr = 8'h10; wdata = 8'h3C;
    seen_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      @(negedge clk);
      write_req = 1'b0; read_req = 1'b0;
      if (valid) seen_valid = 1'b1;
      if (ready) begin
        lat = k;
        break;
      end
    end
    check("both_req_write_latency", 32'(lat), 32'(WL + 1));
    @(negedge clk);
    check("both_req_idle_gap", 32'(busy), 32'(0));
    @(negedge clk);
    check("both_req_read_not_queued", 32'(busy | valid | seen_valid), 32'(0));
    run_txn(1'b0, 8'h10, 8'h00, lat);
    check("both_req_readback_latency", 32'(lat), 32'(RL + 1));
    check("both_req_readback_data", 32'(rdata), 32'(8'h3C));
    @(negedge clk);

    // Reset during s_write_wait drops the write
    write_req = 1'b1; addr = 8'h20; wdata = 8'hFF;
    @(negedge clk);
    write_req = 1'b0;
    check("rst_mid_write_busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_write_ready", 32'(ready), 32'(0));
    check("rst_mid_write_busy",  32'(busy),  32'(0));
    check("rst_mid_write_rdata", 32'(rdata), 32'(0));
    @(negedge clk);
    check("rst_mid_write_no_late_ready", 32'(ready), 32'(0));
    run_txn(1'b0, 8'h20, 8'h00, lat);
    check("rst_mid_write_ram_unchanged", 32'(rdata), 32'(8'h11));
    @(negedge clk);

    // Held read request: back-to-back transactions every RL+2 cycles
    read_req = 1'b1; addr = 8'h05;
    pulses = 0;
    for (int k = 1; k <= 3 * (RL + 2); k++) begin
      @(negedge clk);
      check($sformatf("held_read_valid_c%0d", k), 32'(valid), 32'((k % (RL + 2)) == RL + 1));
      check($sformatf("held_read_busy_c%0d", k),  32'(busy),  32'((k % (RL + 2)) != 0));
      if (valid) begin
        pulses++;
        check($sformatf("held_read_data_c%0d", k), 32'(rdata), 32'(8'hA5));
      end
      if (k == 3 * (RL + 2) - 1) read_req = 1'b0;
    end
    check("held_read_pulse_count", 32'(pulses), 32'(3));

    // Preload every word so the randomized model starts from known contents
    for (int a = 0; a < 2**AW; a++) begin
      mem_m[a] = 8'($urandom);
      run_txn(1'b1, 8'(a), mem_m[a], lat);
      if (lat < 0) check($sformatf("preload_timeout_%0d", a), 32'(lat), 32'(WL + 1));
      @(negedge clk);
    end

    // Randomized traffic against a transaction-level model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0; idle_from = 0; pend = 1'b0; m_rdata = '0;
    acc = 0; lat_m = 0; m_wr = 1'b0; m_addr = '0; m_data = '0;
    for (int it = 0; it < N_RAND; it++) begin
      check("rand_busy",  32'(busy),  32'(n < idle_from));
      check("rand_ready", 32'(ready), 32'(pend && m_wr && n == acc + lat_m));
      check("rand_valid", 32'(valid), 32'(pend && !m_wr && n == acc + lat_m));
      check("rand_rdata", 32'(rdata), 32'(m_rdata));

      rst        = ($urandom_range(0, 63) == 0);
      write_req  = ($urandom_range(0, 3) == 0);
      read_req   = ($urandom_range(0, 2) == 0);
      fault_ena  = 1'($urandom_range(0, 1));
      fault_addr = 8'($urandom_range(0, 7));
      fault_mask = 8'($urandom);
      addr       = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      wdata      = 8'($urandom);

      e = n + 1;
      if (rst) begin
        pend      = 1'b0;
        idle_from = e;
        m_rdata   = '0;
      end else begin
        if (pend && e == acc + lat_m) begin
          if (m_wr) mem_m[m_addr] = m_data;
          else m_rdata = mem_m[m_addr] ^ ((fault_ena && fault_addr == m_addr) ? fault_mask : 8'h00);
        end
        if (n >= idle_from && (write_req || read_req)) begin
          acc       = e;
          m_wr      = write_req;
          lat_m     = write_req ? WL : RL;
          m_addr    = addr;
          m_data    = wdata;
          idle_from = e + lat_m + 1;
          pend      = 1'b1;
        end
      end
      @(negedge clk);
      n++;
    end

    // Final readback of a few words to confirm RAM contents
    rst = 1'b0; write_req = 1'b0; read_req = 1'b0; fault_ena = 1'b0;
    repeat (RL + 3) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      held = mem_m[j];
      run_txn(1'b0, 8'(j), 8'h00, lat);
      check($sformatf("final_readback_%0d", j), 32'(rdata), 32'(held));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
